mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the single memoryModule port between instruction-fetch (port 0) and data (port 1) requesters.
//   Latches one request at a time and drives memoryModule cntrl/addr/dataIn/isIndirect.
//   Holds the operation until dataReady, then returns read data and a one-cycle done pulse to the winner.
//   Round-robin grant prevents either port from starving the other.
// PARAMETERS
//   ramWidth  16  data width; must match memoryModule ramWidth
//   addrSize  8   address width; must match memoryModule addrSize
//   TIMEOUT   64  BUSY cycles before abort; used only with MEM_ARB_TIMEOUT_EN; must be >= 2
// PORTS
//   clk          in   1         single clock, rising edge
//   rstN         in   1         asynchronous, active-low reset
//   req0/req1    in   1         request from port 0 (fetch) / port 1 (data)
//   we0/we1      in   1         1 = write, 0 = read
//   addr0/addr1  in   addrSize  request address
//   wdata0/wdata1 in  ramWidth  write data
//   ind0/ind1    in   1         indirect access; forwarded to isIndirect
//   done0/done1  out  1         one-cycle completion pulse to the owning port
//   rdata        out  ramWidth  read data; valid only in the cycle done0 or done1 is high
//   err          out  1         timeout abort flag, qualified by done; tied 0 without macro
//   busy         out  1         high whenever state != IDLE
//   memCntrl     out  2         to memoryModule cntrl: 00 idle, 01 read, 10 write; 11 is never driven
//   memAddr      out  addrSize  to memoryModule addr
//   memDataIn    out  ramWidth  to memoryModule dataIn
//   memIndirect  out  1         to memoryModule isIndirect
//   memDataOut   in   ramWidth  from memoryModule dataOut
//   memDataReady in   1         from memoryModule dataReady
// BEHAVIOUR
//   Reset (async, rstN=0)
//     - All outputs go to 0 immediately and memCntrl=00; state=IDLE; lastGrant=1.
//     - An in-flight transaction is dropped with no done pulse.
//   FSM states: IDLE -> BUSY -> RELEASE -> IDLE.
//   IDLE
//     - memCntrl=00; memDataReady is ignored.
//     - Only one req high: grant that port.
//     - Both high: grant !lastGrant, so after reset port 0 wins first.
//     - On grant, register we/addr/wdata/ind of the winner and owner=winner; next state BUSY.
//     - lastGrant updates only on grant.
//   BUSY
//     - memCntrl=(we?10:01); memAddr/memDataIn/memIndirect held from the latched values.
//     - Requester inputs are ignored; a req dropped mid-transaction still completes and still pulses done.
//     - On memDataReady=1: rdata<=memDataOut (writes capture it too; the value is don't-care to the requester).
//       Same edge: done[owner]<=1, next state RELEASE.
//   RELEASE
//     - memCntrl=00 for exactly one cycle, so the cache controller returns to idle.
//     - done/rdata visible this cycle; done clears next cycle; next state IDLE.
//     - A new grant is possible in the IDLE cycle that follows, so back-to-back ops are spaced by 1 idle cycle.
//   Latency
//     - req sampled at edge N gives memCntrl active from cycle N+1.
//     - memDataReady seen at edge M gives done high in cycle M+1.
//     - Minimum req-to-done is 3 cycles.
//   Constraints
//     - done0 and done1 are never high together; exactly one done per grant.
//     - rdata holds its last value outside done cycles; err=0 on normal completion.
// CONFIGURATION
//   MEM_ARB_TIMEOUT_EN defined
//     - A $clog2(TIMEOUT+1)-bit counter clears on entry to BUSY and increments each BUSY cycle.
//     - When it reaches TIMEOUT with memDataReady=0: go to RELEASE, done[owner]=1, err=1, rdata=0.
//     - memDataReady and timeout in the same cycle: the ready wins, so err=0.
//   MEM_ARB_TIMEOUT_EN undefined
//     - No counter; BUSY waits indefinitely; err is tied to 0.
// TESTING
//   1. Reset release, req0 read addr=8'h10, memory returns 16'hBEEF after 4 cycles
//      -> memCntrl=01 for 4 cycles; done0 pulses 1 cycle with rdata=16'hBEEF; done1 stays 0.
//   2. req0 and req1 both held high continuously
//      -> grants alternate 0,1,0,1; each done is followed by one memCntrl=00 cycle.
//   3. req1 write addr=8'h22 wdata=16'h1234 ind1=1
//      -> memCntrl=10, memAddr=8'h22, memDataIn=16'h1234, memIndirect=1 until ready; then done1.
//   4. rstN pulled low in the 2nd BUSY cycle
//      -> memCntrl=00 the same cycle; no done; after release, first grant goes to port 0.
//   5. req0 deasserted 1 cycle after grant -> transaction completes; done0 still pulses.
//   6. With MEM_ARB_TIMEOUT_EN and TIMEOUT=8, memDataReady never asserted
//      -> done0 and err high in the cycle after the 8th BUSY cycle, rdata=0; without the macro, busy stays 1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memoryModule port between fetch (0) and data (1).
// Optional BUSY watchdog abort: define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int ramWidth = 16,
    parameter int addrSize = 8
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT  = 64
`endif
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic                req0,
    input  logic                req1,
    input  logic                we0,
    input  logic                we1,
    input  logic [addrSize-1:0] addr0,
    input  logic [addrSize-1:0] addr1,
    input  logic [ramWidth-1:0] wdata0,
    input  logic [ramWidth-1:0] wdata1,
    input  logic                ind0,
    input  logic                ind1,
    output logic                done0,
    output logic                done1,
    output logic [ramWidth-1:0] rdata,
    output logic                err,
    output logic                busy,
    output logic [1:0]          memCntrl,
    output logic [addrSize-1:0] memAddr,
    output logic [ramWidth-1:0] memDataIn,
    output logic                memIndirect,
    input  logic [ramWidth-1:0] memDataOut,
    input  logic                memDataReady
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic                grant;
    logic                win;
    logic                complete;
    logic                abort;
    logic                last_grant;
    logic                owner;
    logic                lat_we;
    logic                lat_ind;
    logic [addrSize-1:0] lat_addr;
    logic [ramWidth-1:0] lat_wdata;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    logic          err_q;
`endif

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        win       = 1'b0;
        complete  = 1'b0;
        abort     = 1'b0;
        unique case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant     = 1'b1;
                    // Contention goes to the port that did not win last time.
                    win       = (req0 && req1) ? ~last_grant : req1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (memDataReady) begin
                    complete  = 1'b1;
                    state_nxt = RELEASE;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (cnt == CW'(TIMEOUT - 1)) begin
                    abort     = 1'b1;
                    state_nxt = RELEASE;
                end
`endif
            end
            RELEASE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            lat_we     <= 1'b0;
            lat_ind    <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rdata      <= '0;
            done0      <= 1'b0;
            done1      <= 1'b0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            if (grant) begin
                last_grant <= win;
                owner      <= win;
                lat_we     <= win ? we1    : we0;
                lat_ind    <= win ? ind1   : ind0;
                lat_addr   <= win ? addr1  : addr0;
                lat_wdata  <= win ? wdata1 : wdata0;
            end
            if (complete) begin
                rdata <= memDataOut;
                done0 <= ~owner;
                done1 <= owner;
            end
            if (abort) begin
                rdata <= '0;
                done0 <= ~owner;
                done1 <= owner;
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= abort;
            if (grant) begin
                cnt <= '0;
            end else if (state == BUSY) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign busy        = (state != IDLE);
    assign memCntrl    = (state == BUSY) ? (lat_we ? 2'b10 : 2'b01) : 2'b00;
    assign memAddr     = lat_addr;
    assign memDataIn   = lat_wdata;
    assign memIndirect = lat_ind;

endmodule
